pi_vector_source: RTL and testbench

- Sequential stimulus/response engine that drives the 16-bit primary-input vector pi00..pi15 of a combinational 16-in/4-out benchmark core.
- Compacts the core's 4-bit response po0..po3 into a 16-bit MISR signature.
- Sits on the driving side of the core: it generates vectors and sinks responses, the opposite end of the pi/po interface.
- Vectors are offered with a valid/ready handshake so a wrapper or scan shell can throttle application.

---
 rtl/pi_vector_source.sv | 114 +++++++++++
 tb/tb_pi_vector_source.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pi_vector_source.sv
// Vector source and response compactor for a 16-in/4-out combinational core: generates
// counter or LFSR vectors over valid/ready and folds responses into a MISR. Optional golden compare under PI_VECTOR_SOURCE_EXPECT_EN.
module pi_vector_source #(
   parameter int unsigned  NUM_VECTORS = 16,
   parameter logic [15:0]  SEED        = 16'hACE1,
   parameter logic [15:0]  MISR_POLY   = 16'h1021
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        mode,
   output logic [15:0] pi_vec,
   output logic        vec_valid,
   input  logic        vec_ready,
   input  logic [3:0]  po_resp,
   output logic [15:0] signature,
`ifdef PI_VECTOR_SOURCE_EXPECT_EN
   input  logic [15:0] expected_sig,
   output logic        pass,
`endif
   output logic        busy,
   output logic        done
);

   // state | meaning
   // IDLE  | waiting for start after reset
   // RUN   | offering vectors, compacting responses
   // DONE  | run complete, signature frozen
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [16:0] LAST_CNT = 17'(NUM_VECTORS - 1);
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   state_t      state, state_nxt;
   logic        hs;
   logic        load;
   logic        mode_q;
   logic [16:0] count;
   logic [15:0] sig_nxt;
   logic [15:0] vec_nxt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      vec_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      hs        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            vec_valid = 1'b1;
            busy      = 1'b1;
            hs        = vec_ready;
            if (vec_ready && (count == LAST_CNT)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sig_nxt = {signature[14:0], 1'b0} ^ (signature[15] ? MISR_POLY : 16'h0000)
              ^ {12'h000, po_resp};
      if (mode_q) vec_nxt = pi_vec[0] ? ((pi_vec >> 1) ^ 16'hB400) : (pi_vec >> 1);
      else        vec_nxt = pi_vec + 16'h0001;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pi_vec    <= 16'h0000;
         signature <= 16'h0000;
         count     <= 17'h0;
         mode_q    <= 1'b0;
      end else if (load) begin
         pi_vec    <= mode ? SEED_EFF : 16'h0000;
         signature <= 16'h0000;
         count     <= 17'h0;
         mode_q    <= mode;
      end else if (hs) begin
         pi_vec    <= vec_nxt;
         signature <= sig_nxt;
         count     <= count + 17'h1;
      end
   end

`ifdef PI_VECTOR_SOURCE_EXPECT_EN
   // Compare against the signature value DONE will hold, so pass lines up with done.
   logic [15:0] sig_d;
   assign sig_d = hs ? sig_nxt : signature;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pass <= 1'b0;
      else          pass <= (state_nxt == ST_DONE) && (sig_d == expected_sig);
   end
`endif

endmodule

// File: tb/tb_pi_vector_source.sv
// Self-checking bench for pi_vector_source: table-driven counter/LFSR runs plus
// hand-written backpressure, restart and async-reset sequences.
module tb_pi_vector_source;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        mode;
   logic [15:0] pi_vec;
   logic        vec_valid;
   logic        vec_ready;
   logic [3:0]  po_resp;
   logic [15:0] signature;
   logic        busy;
   logic        done;
`ifdef PI_VECTOR_SOURCE_EXPECT_EN
   logic [15:0] expected_sig;
   logic        pass;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        mode;
      logic [3:0]  po;
      logic [15:0] exp_vec;
      logic [15:0] exp_sig;
   } vec_t;

   vec_t        tbl[8];
   logic [15:0] sb_q[$];
   logic [15:0] mvec, msig;

   pi_vector_source #(.NUM_VECTORS(4), .SEED(16'hACE1), .MISR_POLY(16'h1021)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
      .pi_vec(pi_vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .po_resp(po_resp), .signature(signature),
`ifdef PI_VECTOR_SOURCE_EXPECT_EN
      .expected_sig(expected_sig), .pass(pass),
`endif
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] p);
      logic [15:0] r;
      r = {s[14:0], 1'b0};
      if (s[15]) r = r ^ 16'h1021;
      return r ^ {12'h000, p};
   endfunction

   // Entered and left at a falling edge.
   task automatic pulse_start(input logic m);
      start = 1'b1; mode = m; vec_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_table(input int first, input int n);
      pulse_start(tbl[first].mode);
      for (int i = first; i < first + n; i++) begin
         vec_ready = 1'b1;
         po_resp   = tbl[i].po;
         chk("tbl_valid", 16'(vec_valid), 16'h1);
         chk("tbl_vec", pi_vec, tbl[i].exp_vec);
         sb_q.push_back(tbl[i].exp_sig);
         @(posedge clock); #1;
         chk("tbl_sig", signature, sb_q.pop_front());
         @(negedge clock);
      end
      vec_ready = 1'b0;
      chk("end_done", 16'(done), 16'h1);
      chk("end_valid", 16'(vec_valid), 16'h0);
      chk("end_busy", 16'(busy), 16'h0);
   endtask

   task automatic handshake();
      logic [3:0] p;
      p = 4'($urandom_range(15));
      vec_ready = 1'b1;
      po_resp   = p;
      chk("hs_vec", pi_vec, mvec);
      msig = misr(msig, p);
      mvec = mvec + 16'h1;
      sb_q.push_back(msig);
      @(posedge clock); #1;
      chk("hs_sig", signature, sb_q.pop_front());
      @(negedge clock);
   endtask

   initial begin
      tbl[0] = '{1'b0, 4'h1, 16'h0000, 16'h0001};
      tbl[1] = '{1'b0, 4'h1, 16'h0001, 16'h0003};
      tbl[2] = '{1'b0, 4'h1, 16'h0002, 16'h0007};
      tbl[3] = '{1'b0, 4'h1, 16'h0003, 16'h000F};
      tbl[4] = '{1'b1, 4'h0, 16'hACE1, 16'h0000};
      tbl[5] = '{1'b1, 4'h0, 16'hE270, 16'h0000};
      tbl[6] = '{1'b1, 4'h0, 16'h7138, 16'h0000};
      tbl[7] = '{1'b1, 4'h0, 16'h389C, 16'h0000};

      reset_n = 1'b0; start = 1'b0; mode = 1'b0; vec_ready = 1'b0; po_resp = 4'h0;
`ifdef PI_VECTOR_SOURCE_EXPECT_EN
      expected_sig = 16'h000F;
`endif
      #12;
      chk("rst_vec", pi_vec, 16'h0000);
      chk("rst_valid", 16'(vec_valid), 16'h0);
      chk("rst_sig", signature, 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
`ifdef PI_VECTOR_SOURCE_EXPECT_EN
      chk("rst_pass", 16'(pass), 16'h0);
`endif
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Counter run, then LFSR run restarted from DONE.
      run_table(0, 4);
`ifdef PI_VECTOR_SOURCE_EXPECT_EN
      chk("pass_hit", 16'(pass), 16'h1);
      expected_sig = 16'h000E;
      @(posedge clock); #1;
      chk("pass_miss", 16'(pass), 16'h0);
      @(negedge clock);
`endif
      run_table(4, 4);

      // Backpressure with start pulsed mid-run.
      pulse_start(1'b0);
      mvec = 16'h0000; msig = 16'h0000;
      handshake();
      handshake();
      for (int j = 0; j < 3; j++) begin
         vec_ready = 1'b0;
         po_resp   = 4'($urandom_range(15));
         start     = (j == 1);
         mode      = 1'b1;
         @(posedge clock); #1;
         chk("bp_vec", pi_vec, mvec);
         chk("bp_sig", signature, msig);
         chk("bp_busy", 16'(busy), 16'h1);
         @(negedge clock);
      end
      start = 1'b0;
      handshake();
      handshake();
      chk("bp_done", 16'(done), 16'h1);

      // Signature frozen in DONE, then restart from DONE.
      vec_ready = 1'b1; po_resp = 4'hF;
      @(posedge clock); #1;
      chk("frozen_sig", signature, msig);
      @(negedge clock);
      start = 1'b1; mode = 1'b0;
      @(posedge clock); #1;
      chk("restart_sig", signature, 16'h0000);
      chk("restart_vec", pi_vec, 16'h0000);
      chk("restart_busy", 16'(busy), 16'h1);
      chk("restart_done", 16'(done), 16'h0);
      @(negedge clock);
      start = 1'b0;
      mvec = 16'h0000; msig = 16'h0000;
      handshake();
      handshake();

      // Asynchronous reset between clock edges.
      @(posedge clock); #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 16'(busy), 16'h0);
      chk("arst_valid", 16'(vec_valid), 16'h0);
      chk("arst_vec", pi_vec, 16'h0000);
      chk("arst_sig", signature, 16'h0000);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         vec_ready = 1'b1;
         chk("idle_busy", 16'(busy), 16'h0);
         chk("idle_vec", pi_vec, 16'h0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
